// File: rtl/uart_rx_bus.sv
// uart_rx_bus: 8N1 UART receiver with a small receive FIFO behind a simple register read/write bus.
// Ports: clk, rst_n (async active-low); addr/rd_en/wr_en/wr_data bus in; rd_data/rd_valid bus out;
//        rx serial in (idle high, asynchronous); irq high while the receive FIFO holds data.

// Generic synchronous FIFO with occupancy count.
// Latency: head_dat shows the oldest entry combinationally; push/pop take effect at the next edge.
// Backpressure: push is dropped when full unless a pop in the same cycle frees the slot.
module uart_rx_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == DEPTH[AW:0]);
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];
    // A concurrent pop frees the head slot, so a push into a full FIFO still fits.
    assign push_ok  = push && (!full || pop);
    assign pop_ok   = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly AW bits wide and wrap naturally.
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// UART receive peripheral: deframes 8N1 characters into a FIFO readable over the bus.
// Latency: byte enters FIFO at the stop-bit sample point; bus reads return data one cycle after rd_en.
// Backpressure: none on rx; a byte arriving with the FIFO full is dropped and OVR is set.
module uart_rx_bus #(
    parameter int DIV        = 104,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] addr,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rx,
    output logic       irq
);
    // DIV must stay within 4..65535 so both reload values fit the 16-bit counter.
    localparam logic [15:0] HALF_RELOAD = 16'(DIV / 2 - 1);
    localparam logic [15:0] BIT_RELOAD  = 16'(DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                state;
    logic [15:0]           cnt;
    logic [2:0]            bit_idx;
    logic [7:0]            shreg;
    logic                  rx_meta;
    logic                  rxs;
    logic                  rxs_prev;
    logic                  ovr;
    logic                  ferr;

    logic                  stop_hit;
    logic                  push_req;
    logic                  ferr_set;
    logic                  ovr_set;
    logic                  ovr_clr;
    logic                  ferr_clr;
    logic                  pop;
    logic [7:0]            rd_mux;
    logic [7:0]            fifo_head;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  unused_bits;

    assign unused_bits = ^{addr[2], wr_data[7:3], wr_data[0]};

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    // All three idle high so leaving reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    // Edge-triggered: a held-low break line never restarts a frame.
                    if (rxs_prev && !rxs) begin
                        state <= S_START;
                        cnt   <= HALF_RELOAD;
                    end
                end
                S_START: begin
                    if (cnt == '0) begin
                        if (!rxs) begin
                            state   <= S_DATA;
                            cnt     <= BIT_RELOAD;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt == '0) begin
                        shreg   <= {rxs, shreg[7:1]};
                        cnt     <= BIT_RELOAD;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= S_STOP;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (cnt == '0) state <= S_IDLE;
                    else           cnt   <= cnt - 16'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign stop_hit = (state == S_STOP) && (cnt == '0);
    assign push_req = stop_hit && rxs;
    assign ferr_set = stop_hit && !rxs;
    assign pop      = rd_en && (addr[1:0] == 2'd0) && !fifo_empty;
    assign ovr_set  = push_req && fifo_full && !pop;
    assign ovr_clr  = wr_en && (addr[1:0] == 2'd1) && wr_data[1];
    assign ferr_clr = wr_en && (addr[1:0] == 2'd1) && wr_data[2];

    uart_rx_fifo #(
        .W  (8),
        .AW (DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_req),
        .push_dat (shreg),
        .pop      (pop),
        .head_dat (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        rd_mux = 8'h00;
        unique case (addr[1:0])
            2'd0:    rd_mux = fifo_empty ? 8'h00 : fifo_head;
            2'd1:    rd_mux = {5'b0, ferr, ovr, !fifo_empty};
            2'd2:    rd_mux = 8'(fifo_count);
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            ovr      <= 1'b0;
            ferr     <= 1'b0;
            irq      <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_mux;
            // Set has priority over a same-cycle software clear.
            ovr  <= (ovr  && !ovr_clr)  || ovr_set;
            ferr <= (ferr && !ferr_clr) || ferr_set;
            irq  <= (fifo_count != '0);
        end
    end
endmodule

// File: tb/tb_uart_rx_bus.sv
module tb_uart_rx_bus;
    localparam int DIV   = 8;
    localparam int DEPTH = 4;
    // Stop bit is judged 2 sync cycles + 1 edge-detect cycle + half a bit + 9 bits after rx falls.
    localparam int ACCEPT = 3 + DIV / 2 + 9 * DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] addr;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rx;
    logic       irq;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] model_q[$];
    bit         m_ovr;
    bit         m_ferr;

    uart_rx_bus #(.DIV(DIV), .DEPTH_LOG2(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rx       (rx),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    task automatic model_frame(input logic [7:0] d, input bit stop_ok);
        if (!stop_ok)                   m_ferr = 1'b1;
        else if (model_q.size() < DEPTH) model_q.push_back(d);
        else                            m_ovr = 1'b1;
    endtask

    function automatic logic [7:0] model_pop();
        if (model_q.size() == 0) return 8'h00;
        return model_q.pop_front();
    endfunction

    function automatic logic [7:0] exp_status();
        return {5'b0, m_ferr, m_ovr, model_q.size() != 0};
    endfunction

    // ---------------- stimulus helpers (all start/end 1 time unit after a rising edge) ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit stop_ok);
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      rx = 1'b0;
            else if (i == 9) rx = stop_ok;
            else             rx = d[i-1];
            tick(DIV);
        end
        rx = 1'b1;
        tick(DIV);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d, output logic v);
        addr  = a;
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        d = rd_data;
        v = rd_valid;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        tick(1);
        wr_en = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] d;
        rst_n = 1'b0; rx = 1'b1; addr = '0; rd_en = 0; wr_en = 0; wr_data = '0;
        tick(3);
        n_cmp++;
        if (rd_data !== 8'h00 || irq !== 1'b0 || rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: rd_data=%h irq=%b rd_valid=%b, want 00/0/0", rd_data, irq, rd_valid);
        end
        rst_n = 1'b1;
        tick(2);
        addr = 3'd1; rd_en = 1'b1;
        #1;
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_early_valid: rd_valid=%b before edge, want 0", rd_valid);
        end
        tick(1);
        rd_en = 1'b0;
        d = rd_data;
        n_cmp++;
        if (rd_valid !== 1'b1 || d !== 8'h00) begin
            n_err++; $display("FAIL reset_status: v=%b d=%h, want 1/00", rd_valid, d);
        end
        tick(1);
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid_pulse: rd_valid=%b one cycle later, want 0", rd_valid);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] d;
        logic       v;
        bit         found;
        found = 0;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                repeat (9 * DIV + DIV / 2) @(posedge clk);
                #1;
                for (int k = 0; k <= DIV / 2 + 2; k++) begin
                    if (irq === 1'b1) begin
                        found = 1;
                        break;
                    end
                    tick(1);
                end
            end
        join
        model_frame(8'hA5, 1'b1);
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL single_irq: irq=%b, want 1 within %0d cycles of stop midpoint", irq, DIV / 2 + 2);
        end
        bus_read(3'd2, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== 8'(model_q.size())) begin
            n_err++; $display("FAIL single_count: v=%b d=%h, want 1/%h", v, d, 8'(model_q.size()));
        end
        bus_read(3'd0, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== model_pop()) begin
            n_err++; $display("FAIL single_data: v=%b d=%h, want 1/a5", v, d);
        end
        bus_read(3'd2, d, v);
        n_cmp++;
        if (d !== 8'h00 || irq !== 1'b0) begin
            n_err++; $display("FAIL single_drained: count=%h irq=%b, want 00/0", d, irq);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d, e;
        logic       v;
        for (int b = 1; b <= 5; b++) begin
            send_byte(8'(b), 1'b1);
            model_frame(8'(b), 1'b1);
        end
        bus_read(3'd2, d, v);
        n_cmp++;
        if (d !== 8'(model_q.size())) begin
            n_err++; $display("FAIL ovf_count: got %h, want %h", d, 8'(model_q.size()));
        end
        bus_read(3'd5, d, v);   // addr[2] must be ignored
        n_cmp++;
        if (d !== exp_status()) begin
            n_err++; $display("FAIL ovf_status: got %h, want %h", d, exp_status());
        end
        for (int i = 0; i < 5; i++) begin
            bus_read(3'd0, d, v);
            e = model_pop();
            n_cmp++;
            if (v !== 1'b1 || d !== e) begin
                n_err++; $display("FAIL ovf_read%0d: v=%b d=%h, want 1/%h", i, v, d, e);
            end
        end
        bus_read(3'd1, d, v);
        n_cmp++;
        if (d !== exp_status()) begin
            n_err++; $display("FAIL ovf_sticky: got %h, want %h", d, exp_status());
        end
        bus_write(3'd1, 8'h02);
        m_ovr = 1'b0;
        bus_read(3'd1, d, v);
        n_cmp++;
        if (d !== exp_status()) begin
            n_err++; $display("FAIL ovf_clear: got %h, want %h", d, exp_status());
        end
    endtask

    task automatic test_framing();
        logic [7:0] d, e;
        logic       v;
        send_byte(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0);
        bus_read(3'd2, d, v);
        n_cmp++;
        if (d !== 8'(model_q.size())) begin
            n_err++; $display("FAIL ferr_count: got %h, want %h", d, 8'(model_q.size()));
        end
        bus_read(3'd1, d, v);
        n_cmp++;
        if (d !== exp_status()) begin
            n_err++; $display("FAIL ferr_status: got %h, want %h", d, exp_status());
        end
        send_byte(8'h7E, 1'b1);
        model_frame(8'h7E, 1'b1);
        bus_read(3'd0, d, v);
        e = model_pop();
        n_cmp++;
        if (d !== e) begin
            n_err++; $display("FAIL ferr_next: got %h, want %h", d, e);
        end
        bus_write(3'd1, 8'h04);
        m_ferr = 1'b0;
        bus_read(3'd1, d, v);
        n_cmp++;
        if (d !== exp_status()) begin
            n_err++; $display("FAIL ferr_clear: got %h, want %h", d, exp_status());
        end
    endtask

    task automatic test_glitch_wrap();
        logic [7:0] d, e, b;
        logic       v;
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(3 * DIV);
        bus_read(3'd1, d, v);
        n_cmp++;
        if (d !== exp_status()) begin
            n_err++; $display("FAIL glitch_status: got %h, want %h", d, exp_status());
        end
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b, 1'b1);
            model_frame(b, 1'b1);
            bus_read(3'd0, d, v);
            e = model_pop();
            n_cmp++;
            if (v !== 1'b1 || d !== e) begin
                n_err++; $display("FAIL wrap_byte%0d: v=%b d=%h, want 1/%h", i, v, d, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b, e;
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b, 1'b1);
            model_frame(b, 1'b1);
        end
        addr  = 3'd0;
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            e = model_pop();
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                n_err++; $display("FAIL b2b_read%0d: v=%b d=%h, want 1/%h", i, rd_valid, rd_data, e);
            end
        end
        rd_en = 1'b0;
        tick(1);
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_valid_end: rd_valid=%b, want 0", rd_valid);
        end
    endtask

    task automatic test_concurrent();
        logic [7:0] d, e, b, got;
        logic       v, gv;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b, 1'b1);
            model_frame(b, 1'b1);
        end
        b = 8'($urandom_range(0, 255));
        fork
            send_byte(b, 1'b1);
            begin
                repeat (ACCEPT - 1) @(posedge clk);
                #1;
                addr  = 3'd0;
                rd_en = 1'b1;
                tick(1);
                rd_en = 1'b0;
                got = rd_data;
                gv  = rd_valid;
            end
        join
        e = model_pop();
        model_frame(b, 1'b1);
        n_cmp++;
        if (gv !== 1'b1 || got !== e) begin
            n_err++; $display("FAIL conc_read: v=%b d=%h, want 1/%h", gv, got, e);
        end
        bus_read(3'd1, d, v);
        n_cmp++;
        if (d !== exp_status()) begin
            n_err++; $display("FAIL conc_status: got %h, want %h", d, exp_status());
        end
        bus_read(3'd2, d, v);
        n_cmp++;
        if (d !== 8'(model_q.size())) begin
            n_err++; $display("FAIL conc_count: got %h, want %h", d, 8'(model_q.size()));
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d, e, b;
        logic       v;
        rx = 1'b0;                 // start bit followed by zero data bits
        tick(DIV + 3 * DIV + DIV / 2);
        rst_n = 1'b0;
        tick(3);
        rx    = 1'b1;
        rst_n = 1'b1;
        model_q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        tick(2 * DIV);
        bus_read(3'd2, d, v);
        n_cmp++;
        if (d !== 8'h00 || irq !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_empty: count=%h irq=%b, want 00/0", d, irq);
        end
        bus_read(3'd1, d, v);
        n_cmp++;
        if (d !== exp_status()) begin
            n_err++; $display("FAIL rst_mid_status: got %h, want %h", d, exp_status());
        end
        b = 8'($urandom_range(0, 255));
        send_byte(b, 1'b1);
        model_frame(b, 1'b1);
        bus_read(3'd0, d, v);
        e = model_pop();
        n_cmp++;
        if (d !== e) begin
            n_err++; $display("FAIL rst_mid_next: got %h, want %h", d, e);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_overflow();
        test_framing();
        test_glitch_wrap();
        test_back_to_back();
        test_concurrent();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_bus.md
Name: uart_rx_bus

Overview:
- Serial UART receiver peripheral on the CPU memory bus; the receive-direction counterpart to the existing transmit-only UART peripheral.
- Samples the asynchronous `rx` pin and deframes 8N1 characters into a 4-entry receive FIFO.
- Exposes the received data and status to the CPU through the standard peripheral handshake: addr / rd_en / rd_data / rd_valid / wr_en / wr_data.
- Intended bus mapping: a free 4 KB window in the peripheral region, addr[15:12]=4'b0110.

Parameters:
- DIV, 104: clock cycles per bit (12 MHz / 115200). Legal range 4..65535.
- DEPTH_LOG2, 2: log2 of FIFO depth (default depth 4).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  3  register offset within the peripheral.
- rd_en  in  1  bus read strobe, one cycle.
- rd_data  out  8  read data.
- rd_valid  out  1  read data valid pulse.
- wr_en  in  1  bus write strobe, one cycle.
- wr_data  in  8  write data.
- rx  in  1  serial input, idle high, asynchronous to clk.
- irq  out  1  high while FIFO is non-empty.

Behaviour:
- Interface: already decided — one clock; reset is asynchronous and active-low.
- Reset values:
  - rd_data=0, rd_valid=0, irq=0.
  - FIFO empty, flags OVR=0 and FERR=0, FSM in IDLE.
  - Both rx synchroniser flops reset to 1.
  - Reset mid-frame discards the partial character.
- rx sync: 2-flop synchroniser. All FSM decisions use the synchronised value rxs.
- FSM states IDLE, START, DATA, STOP. Counter cnt is 16 bits; bit index is 3 bits.
  - IDLE: falling edge of rxs (prev 1, now 0) -> START, cnt=DIV/2-1.
  - START: at cnt==0, if rxs==0 -> DATA with cnt=DIV-1, bit=0; else glitch -> IDLE with no flag set.
  - DATA: at cnt==0, shift rxs into shreg LSB-first and reload cnt=DIV-1. After bit 7 -> STOP.
  - STOP: at cnt==0:
    - rxs==1: push shreg into FIFO, or set OVR and drop the byte if FIFO is full. -> IDLE.
    - rxs==0: set FERR, discard byte, -> IDLE.
  - A continuous low (break) does not retrigger; IDLE waits for a new falling edge.
- Register map, on addr[1:0]; addr[2] ignored:
  - 0 DATA: read returns the FIFO head and pops it. Empty FIFO returns 0x00 with no pop. Writes ignored.
  - 1 STATUS: read returns {5'b0, FERR, OVR, avail}, where avail = FIFO non-empty. Write 1 to bit1 clears OVR; write 1 to bit2 clears FERR.
  - 2 COUNT: read returns FIFO occupancy, 0..DEPTH. Read-only.
  - 3: reads 0x00, writes ignored.
- Read timing:
  - rd_valid goes high exactly 1 cycle after rd_en, for 1 cycle.
  - rd_data is registered in that same cycle and holds until the next read.
  - Back-to-back rd_en on consecutive cycles is legal: each produces its own rd_valid and pops at most one entry.
- Simultaneous events:
  - Push and pop in the same cycle: both happen, occupancy unchanged. A pop on a full FIFO frees a slot for the concurrent push, so no OVR.
  - A flag being set and cleared in the same cycle: set wins.
  - rd_en and wr_en together: both are honoured.
- FIFO: circular with DEPTH_LOG2-bit read/write pointers that wrap naturally, plus a (DEPTH_LOG2+1)-bit count.
- irq = (count != 0), registered.

Test Plan:
- Reset and idle (DIV=8): rst_n low for 3 cycles with rx=1.
  - Expect rd_data=0, irq=0; STATUS read returns 0x00 with rd_valid one cycle after rd_en.
- Single byte (DIV=8): send 0xA5 at 8 clk/bit.
  - Expect irq=1 within DIV/2+2 cycles after the stop-bit midpoint, COUNT=1.
  - DATA read returns 0xA5; then COUNT=0, irq=0.
- Overflow: send 0x01..0x05 with no reads.
  - Expect COUNT=4, STATUS=0x03.
  - Reads return 0x01, 0x02, 0x03, 0x04; 0x05 is lost.
  - Write 0x02 to STATUS -> STATUS=0x00.
- Framing error: send 0x3C with stop bit driven low.
  - Expect FIFO unchanged and STATUS bit2 set.
  - Next valid 0x7E is received correctly.
- Glitch and wrap:
  - A 2-cycle low pulse on rx yields no byte.
  - Stream 10 bytes, reading each after arrival: FIFO pointers wrap and all 10 bytes are returned in order.
- Concurrency and reset:
  - With FIFO full, issue a DATA read in the same cycle the stop bit is accepted: no OVR, COUNT stays 4.
  - Assert rst_n mid-DATA: FIFO empty and the next byte is received cleanly.
